posit_encode_es2: RTL

Pipelined encoder that turns the serialized raw sum produced by the es=2 posit adder into a packed N-bit posit word. Each input word carries sign, scale, fraction, inf and zero fields. The block sits directly after the adder's result port and shares its start/done valid style. It performs regime/exponent packing, round-to-nearest-even, saturation and two's-complement negation, and accepts one operation per cycle.

---
 rtl/posit_encode_es2.sv | 132 +++++++++++++
 1 files changed

// File: rtl/posit_encode_es2.sv
// rtl/posit_encode_es2.sv - three-stage es=2 posit encoder with RNE rounding and saturation
module posit_encode_es2 #(
  parameter int POSIT_N = 32,
  parameter int FRAC_W  = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [FRAC_W+10:0]  in_sum,
  output logic [POSIT_N-1:0]  result,
  output logic                done
);
  localparam int IW   = FRAC_W + 11;
  // Regime pattern (2) + exponent (2) + fraction + padding that catches every
  // bit shifted out of the body, so sticky never loses information.
  localparam int YW   = 4 + FRAC_W + POSIT_N;
  localparam int SMAX = 4 * (POSIT_N - 2);
  localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
  localparam logic [POSIT_N-1:0] MINPOS = {{(POSIT_N-1){1'b0}}, 1'b1};
  localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};

  logic v1, v2, v3;

  // Stage 1: registered raw input and its decoded fields
  logic [IW-1:0]        s1_in;
  logic                 s1_sgn, s1_inf, s1_zero;
  logic signed [7:0]    s1_scale;
  logic [FRAC_W-1:0]    s1_frac;
  logic signed [5:0]    s1_k;
  logic [4:0]           s1_m;
  logic                 s1_hi, s1_lo;

  // Stage 2: decoded operands ready for the regime shift
  logic                 s2_sgn, s2_kneg, s2_inf, s2_zero, s2_hi, s2_lo;
  logic [4:0]           s2_m;
  logic [1:0]           s2_e;
  logic [FRAC_W-1:0]    s2_frac;
  logic signed [YW-1:0] s2_y, s2_ys;
  logic [POSIT_N-2:0]   s2_body;
  logic                 s2_guard, s2_sticky;

  // Stage 3: truncated body plus rounding bits
  logic                 s3_sgn, s3_inf, s3_zero, s3_hi, s3_lo;
  logic [POSIT_N-2:0]   s3_body;
  logic                 s3_guard, s3_sticky;
  logic                 s3_rnd;
  logic [POSIT_N-1:0]   s3_sum, s3_mag, s3_res;

  // Split the input word; k = scale >>> 2 and the shift count that builds the regime
  always_comb begin
    s1_sgn   = s1_in[IW-1];
    s1_scale = s1_in[IW-2 -: 8];
    s1_frac  = s1_in[FRAC_W+1:2];
    s1_inf   = s1_in[1];
    s1_zero  = s1_in[0];
    s1_k     = s1_scale[7:2];
    // k >= 0 needs k extra copies of the leading one; k < 0 needs -k-1 extra zeros (= ~k)
    s1_m     = s1_k[5] ? ~s1_k[4:0] : s1_k[4:0];
    s1_hi    = (s1_scale > SMAX);
    s1_lo    = (s1_scale < -SMAX);
  end

  // Regime built by arithmetic-shifting a seeded "10"/"01" pattern, then split into body/guard/sticky
  always_comb begin
    s2_y      = {~s2_kneg, s2_kneg, s2_e, s2_frac, {POSIT_N{1'b0}}};
    s2_ys     = s2_y >>> s2_m;
    s2_body   = s2_ys[YW-1 -: POSIT_N-1];
    s2_guard  = s2_ys[YW-POSIT_N];
    s2_sticky = |s2_ys[YW-POSIT_N-1:0];
  end

  // Round to nearest even, clamp into [minpos, maxpos], apply specials and sign
  always_comb begin
    s3_rnd = s3_guard & (s3_body[0] | s3_sticky);
    s3_sum = {1'b0, s3_body} + (s3_rnd ? MINPOS : '0);
    if (s3_hi || s3_sum[POSIT_N-1])
      s3_mag = MAXPOS;
    else if (s3_lo || (s3_sum == '0))
      s3_mag = MINPOS;
    else
      s3_mag = s3_sum;
    if (s3_inf)
      s3_res = NAR;
    else if (s3_zero)
      s3_res = '0;
    else if (s3_sgn)
      s3_res = ~s3_mag + MINPOS;
    else
      s3_res = s3_mag;
  end

  // Pipeline data registers; validity is tracked separately so these need no reset
  always_ff @(posedge clk) begin
    s1_in     <= in_sum;
    s2_sgn    <= s1_sgn;
    s2_kneg   <= s1_k[5];
    s2_m      <= s1_m;
    s2_e      <= s1_scale[1:0];
    s2_frac   <= s1_frac;
    s2_inf    <= s1_inf;
    s2_zero   <= s1_zero;
    s2_hi     <= s1_hi;
    s2_lo     <= s1_lo;
    s3_sgn    <= s2_sgn;
    s3_body   <= s2_body;
    s3_guard  <= s2_guard;
    s3_sticky <= s2_sticky;
    s3_inf    <= s2_inf;
    s3_zero   <= s2_zero;
    s3_hi     <= s2_hi;
    s3_lo     <= s2_lo;
  end

  // Valid chain and output register; result only changes when a new value completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      if (start) v1 <= 1'b1;
      else       v1 <= 1'b0;
      v2   <= v1;
      v3   <= v2;
      done <= v3;
      if (v3) result <= s3_res;
    end
  end

endmodule
